// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes enter a FIFO over valid/ready and leave LSB first on tx.
// Latency: a byte accepted into an empty FIFO while idle drives the start bit one clock later.
// Backpressure: s_ready drops only while the FIFO is full; queued bytes are sent back-to-back.
module uart_tx_fifo #(
    parameter int FIFO_AW = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    input  logic [7:0]         s_data,
    output logic               s_ready,
    input  logic               baud_pulse,
    output logic               baud_en,
    output logic               tx,
    output logic               busy,
    output logic               tx_done,
    output logic [FIFO_AW:0]   fifo_count
);

    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state;
    logic [7:0]           mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr;
    logic [FIFO_AW-1:0]   rd_ptr;
    logic [7:0]           shreg;
    logic [2:0]           bit_cnt;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;

    // The count never exceeds DEPTH, so its MSB alone marks a full FIFO.
    assign full    = fifo_count[FIFO_AW];
    assign empty   = (fifo_count == '0);
    assign s_ready = !full && !rst;
    assign push    = s_valid && s_ready;

    // A byte leaves the FIFO whenever a frame is loaded: straight from IDLE,
    // or at the end of a stop bit so the next start bit follows without a gap.
    assign pop  = !empty && ((state == IDLE) || ((state == STOP) && baud_pulse));

    assign busy = (state != IDLE) || !empty;

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the count alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Frame sequencer with registered line, baud enable and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            baud_en <= 1'b0;
            tx_done <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        shreg   <= mem[rd_ptr];
                        bit_cnt <= '0;
                        baud_en <= 1'b1;
                        tx      <= 1'b0;
                        state   <= START;
                    end else begin
                        tx      <= 1'b1;
                        baud_en <= 1'b0;
                    end
                end
                START: begin
                    if (baud_pulse) begin
                        tx    <= shreg[0];
                        shreg <= {1'b0, shreg[7:1]};
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (baud_pulse) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            tx    <= shreg[0];
                            shreg <= {1'b0, shreg[7:1]};
                        end
                    end
                end
                STOP: begin
                    if (baud_pulse) begin
                        tx_done <= 1'b1;
                        if (!empty) begin
                            // Keep the baud generator running so the next start bit
                            // is a full period with no idle gap.
                            shreg   <= mem[rd_ptr];
                            bit_cnt <= '0;
                            tx      <= 1'b0;
                            state   <= START;
                        end else begin
                            baud_en <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a frame-timing model of the line plus a serial receiver,
// driven by a baud generator that holds its counter cleared while baud_en is low.
module tb_uart_tx_fifo;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic [7:0]    s_data;
    logic          s_ready;
    logic          baud_pulse = 1'b0;
    logic          baud_en;
    logic          tx;
    logic          busy;
    logic          tx_done;
    logic [AW:0]   fifo_count;

    uart_tx_fifo #(.FIFO_AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .baud_pulse (baud_pulse),
        .baud_en    (baud_en),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int bit_clks = 16;
    bit force_pulse = 1'b0;
    int gen_cnt = 0;
    int cyc = 0;
    bit check_en = 1'b0;
    int done_cnt = 0;
    int done_cyc[$];
    bit log_en = 1'b0;
    logic txlog[$];
    logic [7:0] mq[$];
    logic [7:0] exp_rx[$];
    logic [7:0] rx_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return b[idx-1];
    endfunction

    function automatic int find_low();
        foreach (txlog[i]) begin
            if (txlog[i] === 1'b0) return i;
        end
        return -1;
    endfunction

    function automatic logic log_at(input int i);
        if (i < 0 || i >= txlog.size()) return 1'bx;
        return txlog[i];
    endfunction

    // Baud generator: pulse every bit_clks cycles while enabled, cleared otherwise.
    always @(negedge clk) begin
        if (force_pulse) begin
            baud_pulse = ~baud_pulse;
            gen_cnt = 0;
        end else if (baud_en !== 1'b1) begin
            baud_pulse = 1'b0;
            gen_cnt = 0;
        end else if (gen_cnt == bit_clks - 1) begin
            baud_pulse = 1'b1;
            gen_cnt = 0;
        end else begin
            baud_pulse = 1'b0;
            gen_cnt++;
        end
    end

    // Line model, per-cycle comparison, done log and serial receiver.
    bit         m_active = 1'b0;
    bit         m_done = 1'b0;
    logic [7:0] m_fb = 8'h00;
    int         m_tick = 0;
    bit         rx_busy = 1'b0;
    int         rx_t = 0;
    logic [9:0] rx_bits = '0;
    logic       prev_tx = 1'b1;

    always begin
        bit   acc;
        logic exp_tx;
        int   k;
        logic [7:0] got;
        @(posedge clk);
        cyc++;
        if (rst === 1'b1) begin
            mq.delete();
            exp_rx.delete();
            m_active = 1'b0;
            m_done = 1'b0;
        end else begin
            acc = (s_valid === 1'b1) && (mq.size() < DEPTH);
            m_done = 1'b0;
            if (m_active) begin
                m_tick++;
                if (m_tick == 10 * bit_clks) begin
                    m_done = 1'b1;
                    m_active = 1'b0;
                end
            end
            if (!m_active && mq.size() != 0) begin
                m_fb = mq.pop_front();
                exp_rx.push_back(m_fb);
                m_active = 1'b1;
                m_tick = 0;
            end
            if (acc) mq.push_back(s_data);
        end
        #1;
        if (check_en) begin
            exp_tx = m_active ? frame_bit(m_fb, m_tick / bit_clks) : 1'b1;
            check("tx", tx, exp_tx);
            check("baud_en", baud_en, m_active);
            check("busy", busy, m_active || (mq.size() != 0));
            check("tx_done", tx_done, m_done);
            check("fifo_count", fifo_count, mq.size());
            check("s_ready", s_ready, (rst !== 1'b1) && (mq.size() < DEPTH));
        end
        if (tx_done === 1'b1) begin
            done_cnt++;
            done_cyc.push_back(cyc);
        end
        if (log_en) txlog.push_back(tx);
        if (rst === 1'b1) begin
            rx_busy = 1'b0;
        end else if (rx_busy) begin
            rx_t++;
            if (rx_t % bit_clks == bit_clks / 2) begin
                k = rx_t / bit_clks;
                rx_bits[k] = tx;
                if (k == 9) begin
                    rx_busy = 1'b0;
                    got = rx_bits[8:1];
                    check("rx_framing", {rx_bits[9], rx_bits[0]}, 2'b10);
                    rx_log.push_back(got);
                    if (exp_rx.size() == 0) check("rx_extra_byte", got, 32'hffff_ffff);
                    else check("rx_byte", got, exp_rx.pop_front());
                end
            end
        end else if (prev_tx === 1'b1 && tx === 1'b0) begin
            rx_busy = 1'b1;
            rx_t = 0;
        end
        prev_tx = tx;
    end

    task automatic push1(input logic [7:0] b, output int edge_no);
        int i;
        for (i = 0; i < 5000 && s_ready !== 1'b1; i++) @(negedge clk);
        check("push_ready_timeout", i < 5000, 1);
        s_valid = 1'b1;
        s_data = b;
        edge_no = cyc + 1;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget && busy !== 1'b0; i++) @(negedge clk);
        check("idle_timeout", i < budget, 1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        bad++;
        $display("FAIL watchdog: got no finish expected finish by 1000000");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e, ea, eb, s, w, d0, r0, b, first_stall, errs, lc0, tgt, i;
        logic [9:0]  p10;
        logic [19:0] p20;
        rst = 1'b1;
        s_valid = 1'b0;
        s_data = 8'h00;
        repeat (2) @(negedge clk);
        check_en = 1'b1;
        check("rst_tx", tx, 1);
        check("rst_baud_en", baud_en, 0);
        check("rst_busy", busy, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_s_ready_low", s_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("s_ready_after_rst", s_ready, 1);

        // Reset while idle.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_rst_tx", tx, 1);
        check("idle_rst_fifo_count", fifo_count, 0);

        // Single byte 0xA5 at 217 clocks per bit.
        bit_clks = 217;
        txlog.delete();
        lc0 = cyc;
        log_en = 1'b1;
        d0 = done_cnt;
        push1(8'hA5, e);
        wait_idle(4000);
        log_en = 1'b0;
        s = find_low();
        check("a5_start_found", s >= 0, 1);
        check("a5_latency", lc0 + 1 + s, e + 1);
        for (int j = 0; j < 10; j++) p10[j] = log_at(s + j * 217 + 108);
        check("a5_bits", p10, 10'b1101001010);
        w = 0;
        while (s >= 0 && log_at(s + w) === 1'b0 && w < 1000) w++;
        check("a5_start_width", (w >= 216 && w <= 218), 1);
        check("a5_done_count", done_cnt - d0, 1);
        check("a5_rx", rx_log.size() > 0 ? rx_log[rx_log.size()-1] : 32'hffff, 8'hA5);

        // Boundary data 0x00 then 0xFF.
        bit_clks = 16;
        txlog.delete();
        log_en = 1'b1;
        r0 = rx_log.size();
        push1(8'h00, e);
        push1(8'hFF, e);
        wait_idle(1000);
        log_en = 1'b0;
        s = find_low();
        for (int j = 0; j < 20; j++) p20[j] = log_at(s + j * 16 + 8);
        check("bnd_bits", p20, 20'b11111111101000000000);
        check("bnd_rx_count", rx_log.size() - r0, 2);
        if (rx_log.size() >= r0 + 2) begin
            check("bnd_rx_00", rx_log[r0], 8'h00);
            check("bnd_rx_ff", rx_log[r0+1], 8'hFF);
        end

        // Burst 0x00..0x13 with s_valid held.
        d0 = done_cyc.size();
        r0 = rx_log.size();
        b = 0;
        first_stall = -1;
        for (int g = 0; g < 6000 && b < 20; g++) begin
            s_valid = 1'b1;
            s_data = b[7:0];
            if (s_ready === 1'b1) b++;
            else if (first_stall < 0) first_stall = b;
            @(negedge clk);
        end
        s_valid = 1'b0;
        check("burst_accept_before_stall", first_stall, 17);
        check("burst_all_accepted", b, 20);
        wait_idle(5000);
        check("burst_done_count", done_cyc.size() - d0, 20);
        errs = 0;
        for (int j = d0 + 1; j < done_cyc.size(); j++)
            if (done_cyc[j] - done_cyc[j-1] != 160) errs++;
        check("burst_frame_spacing_errs", errs, 0);
        check("burst_rx_count", rx_log.size() - r0, 20);
        errs = 0;
        for (int j = 0; j < 20 && r0 + j < rx_log.size(); j++)
            if (rx_log[r0+j] !== j[7:0]) errs++;
        check("burst_rx_order_errs", errs, 0);

        // Push on the exact cycle STOP pops a queued byte.
        r0 = rx_log.size();
        d0 = done_cnt;
        push1(8'h11, ea);
        push1(8'h22, eb);
        tgt = ea + 1 + 160;
        for (i = 0; i < 1000 && cyc < tgt - 1; i++) @(negedge clk);
        check("pdp_count_before", fifo_count, 1);
        s_valid = 1'b1;
        s_data = 8'h33;
        @(negedge clk);
        s_valid = 1'b0;
        check("pdp_count_after", fifo_count, 1);
        check("pdp_done_aligned", tx_done, 1);

        // Drain: the last stop bit drops baud_en and busy together.
        for (i = 0; i < 2000 && done_cnt < d0 + 3; i++) @(negedge clk);
        check("drain_reached", i < 2000, 1);
        check("drain_done_pulse", tx_done, 1);
        check("drain_baud_en", baud_en, 0);
        check("drain_busy", busy, 0);
        @(negedge clk);
        check("drain_done_single", tx_done, 0);
        force_pulse = 1'b1;
        repeat (9) @(negedge clk);
        force_pulse = 1'b0;
        check("idle_pulse_tx", tx, 1);
        check("idle_pulse_baud_en", baud_en, 0);
        check("pdp_rx_count", rx_log.size() - r0, 3);
        if (rx_log.size() >= r0 + 3)
            check("pdp_rx_seq", {rx_log[r0], rx_log[r0+1], rx_log[r0+2]}, 24'h112233);
        repeat (4) @(negedge clk);

        // Reset mid-frame with a second byte queued.
        push1(8'h3C, e);
        push1(8'hC3, e);
        repeat (40) @(negedge clk);
        d0 = done_cnt;
        r0 = rx_log.size();
        rst = 1'b1;
        @(negedge clk);
        check("mf_rst_tx", tx, 1);
        check("mf_rst_baud_en", baud_en, 0);
        check("mf_rst_busy", busy, 0);
        check("mf_rst_fifo_count", fifo_count, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mf_s_ready", s_ready, 1);
        check("mf_no_done", done_cnt - d0, 0);
        push1(8'h5A, e);
        wait_idle(1000);
        check("mf_rx_count", rx_log.size() - r0, 1);
        check("mf_rx_byte", rx_log.size() > 0 ? rx_log[rx_log.size()-1] : 32'hffff, 8'h5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter for the uart_led_demo design. It accepts bytes over a valid/ready stream into an internal FIFO and serialises them as 8N1 frames, LSB first, on `tx`. Bit timing comes from the shared `baud_pulse_gen`: this block drives that generator's `en` and consumes its `baud_pulse`. It is the transmit-side counterpart to `uart_rx` and carries its own buffering, so upstream logic can push bursts without waiting on `busy`.

## Interface

- `FIFO_AW`, 4: FIFO address width. Depth is 2^FIFO_AW entries.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  upstream byte valid.
- `s_data`  in  8  upstream byte.
- `s_ready`  out  1  FIFO can accept. Combinational: `!full && !rst`.
- `baud_pulse`  in  1  one-cycle pulse per bit period, from `baud_pulse_gen`.
- `baud_en`  out  1  drives `baud_pulse_gen.en`. `baud_pulse_gen` holds its counter cleared while `en` is low.
- `tx`  out  1  serial line. Registered; idles high.
- `busy`  out  1  high when the state is not IDLE or the FIFO is non-empty.
- `tx_done`  out  1  one-cycle pulse when a stop bit completes.
- `fifo_count`  out  FIFO_AW+1  number of bytes currently held in the FIFO.

## Operation

- **FIFO**
  - Push on `s_valid && s_ready`.
  - Pop is internal, on frame load.
  - Pointers wrap modulo 2^FIFO_AW. `fifo_count` ranges 0..2^FIFO_AW.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Push while full cannot occur, because `s_ready` is low.
- **FSM states:** IDLE, START, DATA, STOP.
  - **IDLE:** `tx`=1, `baud_en`=0. If `fifo_count`≠0, pop into `shreg`, clear `bit_cnt`, set `baud_en`=1 and `tx`=0, and go to START.
  - **START:** on `baud_pulse`, set `tx`=`shreg[0]`, shift `shreg` right, and go to DATA.
  - **DATA:** on `baud_pulse`, increment `bit_cnt`.
    - If `bit_cnt`==7: set `tx`=1 and go to STOP.
    - Otherwise: set `tx`=`shreg[0]` and shift.
  - **STOP:** on `baud_pulse`, pulse `tx_done`.
    - If `fifo_count`≠0: pop, set `tx`=0, and go to START with `baud_en` held high. No idle gap between frames.
    - Otherwise: set `baud_en`=0 and go to IDLE.
- A frame is exactly 10 baud intervals: 1 start bit, 8 data bits LSB first, 1 stop bit.
- `baud_pulse` is ignored in IDLE.

## Timing

- **Reset values** (the cycle after `rst` is sampled high):
  - `tx`=1, `baud_en`=0, `busy`=0, `tx_done`=0, `fifo_count`=0, state IDLE.
  - `s_ready`=0 while `rst` is high, and 1 the first cycle after.
- **Latency:** a byte accepted at edge E0 into an empty FIFO while the FSM is IDLE gives `fifo_count`=1 after E0. The pop at E1 drives `tx` low after E1, so first start-bit edge is 1 clock after acceptance.
- **Bit widths:** each bit lasts from the edge that drives it to the edge sampling the next `baud_pulse`. With `baud_pulse_gen` cleared while `en` is low, the start bit is one full baud period.
- **`tx_done`:** asserted for exactly the clock following the STOP-state `baud_pulse`.
- **Full FIFO:** `s_ready` re-rises the cycle after each pop.
- **Simultaneous push and pop:** when the FIFO is full, `s_ready` is low, so this only occurs below full. Below full it is legal, and `fifo_count` is unchanged.
- **Reset mid-frame:** the partial frame is abandoned and the FIFO is flushed. `tx`=1 and `baud_en`=0 from the next cycle.
- **Bus hold:** `s_data` is sampled only on the accepting edge. No combinational path from `baud_pulse` to `tx`.

## Test plan

- **Reset:** assert `rst` for 3 cycles mid-idle, then mid-frame.
  - Expect `tx`=1, `baud_en`=0, `busy`=0, `fifo_count`=0 the next cycle.
  - Expect no `tx_done`, and the next pushed byte transmitted cleanly.
- **Single byte:** push 0xA5 with CLK_FREQ=25 MHz and 115200 baud (217 clocks/bit).
  - Expect line sequence 0,1,0,1,0,0,1,0,1,1, each bit 217±1 clocks.
  - Expect a single `tx_done` pulse, and `uart_rx` reporting 0xA5.
- **Burst:** hold `s_valid` with bytes 0x00..0x13.
  - Expect exactly 17 bytes accepted before `s_ready` falls: 16 stored plus 1 popped.
  - Expect `s_ready` high again one cycle after each subsequent pop.
  - Expect all 20 frames back-to-back with no high gap between stop and start, and `uart_rx` receiving 0x00..0x13 in order.
- **Boundary data:** push 0x00 then 0xFF.
  - Expect 9 low bit-times followed by a stop bit, then a start bit followed by 9 high bit-times.
  - Expect `uart_rx` to match both bytes.
- **Push during pop:** push the next byte on the exact cycle STOP pops a queued byte.
  - Expect `fifo_count` unchanged that cycle and no byte lost or duplicated.
- **Drain:** after the last frame completes:
  - `baud_en` falls with the STOP→IDLE transition.
  - `busy` falls the same cycle.
  - Further `baud_pulse` inputs leave `tx`=1.
